// File: rtl/ctrl_pkg.sv
// Shared types for the multicycle control block: FSM states, opcodes, control bundle.
package ctrl_pkg;

  localparam int unsigned ALUOP_W = 3;
  localparam logic [ALUOP_W-1:0] ALUOP_PASS = 3'b111;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    EXEC = 3'd1,
    MEM  = 3'd2,
    WB   = 3'd3,
    TRAP = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    OP_AND   = 3'b000,
    OP_ADD   = 3'b001,
    OP_XOR   = 3'b010,
    OP_BNE   = 3'b011,
    OP_LS    = 3'b100,
    OP_RS    = 3'b101,
    OP_LOAD  = 3'b110,
    OP_STORE = 3'b111
  } opcode_t;

  typedef struct packed {
    logic [ALUOP_W-1:0] alu_op;
    logic               reg_dst;
    logic               branch;
    logic               mem_to_reg;
    logic               mem_write;
    logic               alu_src;
    logic               reg_write;
    logic               add;
    logic               is_mem;
    logic               undef;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_decode.sv
// Combinational opcode -> control bundle table; codes >= 8 decode as a flagged NOP.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int unsigned OPBITS = 3
) (
  input  logic [OPBITS-1:0] i_opcode,
  output ctrl_t             o_ctrl
);

  logic w_undef;

  // Any set bit above the 3-bit defined range makes the opcode undefined
  assign w_undef = ((i_opcode >> 3) != '0);

  // Decode table
  always_comb begin
    o_ctrl        = '0;
    o_ctrl.alu_op = ALUOP_PASS;
    if (w_undef) begin
      o_ctrl.undef = 1'b1;
    end else begin
      case (opcode_t'(i_opcode[2:0]))
        OP_AND: begin
          o_ctrl.alu_op    = 3'b000;
          o_ctrl.reg_dst   = 1'b1;
          o_ctrl.reg_write = 1'b1;
        end
        OP_ADD: begin
          o_ctrl.alu_op    = 3'b001;
          o_ctrl.alu_src   = 1'b1;
          o_ctrl.add       = 1'b1;
          o_ctrl.reg_dst   = 1'b1;
          o_ctrl.reg_write = 1'b1;
        end
        OP_XOR: begin
          o_ctrl.alu_op    = 3'b010;
          o_ctrl.reg_dst   = 1'b1;
          o_ctrl.reg_write = 1'b1;
        end
        OP_BNE: begin
          o_ctrl.alu_op = 3'b011;
          o_ctrl.branch = 1'b1;
        end
        OP_LS: begin
          o_ctrl.alu_op    = 3'b100;
          o_ctrl.alu_src   = 1'b1;
          o_ctrl.reg_write = 1'b1;
        end
        OP_RS: begin
          o_ctrl.alu_op    = 3'b101;
          o_ctrl.alu_src   = 1'b1;
          o_ctrl.reg_write = 1'b1;
        end
        OP_LOAD: begin
          o_ctrl.alu_op     = 3'b110;
          o_ctrl.alu_src    = 1'b1;
          o_ctrl.mem_to_reg = 1'b1;
          o_ctrl.reg_write  = 1'b1;
          o_ctrl.is_mem     = 1'b1;
        end
        OP_STORE: begin
          o_ctrl.alu_op    = 3'b111;
          o_ctrl.mem_write = 1'b1;
          o_ctrl.is_mem    = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control sequencer: latches one instruction from fetch and walks it
// through EXEC/MEM/WB, gating datapath write strobes to the right cycle.
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN (undefined opcode -> sticky TRAP).
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int unsigned MCODEBITS = 9,
  parameter int unsigned OPBITS    = 3,
  parameter int unsigned OPWIDTH   = 3,
  parameter int unsigned MEM_LAT   = 2
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 instr_valid,
  input  logic [MCODEBITS-1:0] instr,
  output logic                 instr_ready,
  input  logic                 stall,
  output logic                 RegDst,
  output logic                 Branch,
  output logic                 MemtoReg,
  output logic                 MemWrite,
  output logic                 ALUSrc,
  output logic                 RegWrite,
  output logic                 Add,
  output logic [OPWIDTH-1:0]   ALUOp,
  output logic                 busy,
  output logic                 done,
  output logic                 illegal
);

  localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [MCODEBITS-1:0] r_instr;
  logic [MCODEBITS-1:0] w_instr_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  ctrl_t                w_ctrl;
  logic                 w_unused_instr;

  // Only the opcode field steers control; operand bits ride along in the register
  assign w_unused_instr = ^r_instr;

  ctrl_decode #(.OPBITS(OPBITS)) u_decode (
    .i_opcode (r_instr[MCODEBITS-1 -: OPBITS]),
    .o_ctrl   (w_ctrl)
  );

  // State, instruction and MEM-counter registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
      r_instr <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_instr <= w_instr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic and per-state strobe gating; stall freezes and kills writes
  always_comb begin
    w_state_nxt = r_state;
    w_instr_nxt = r_instr;
    w_cnt_nxt   = r_cnt;
    instr_ready = 1'b0;
    busy        = 1'b1;
    ALUOp       = OPWIDTH'(w_ctrl.alu_op);
    RegDst      = w_ctrl.reg_dst;
    MemtoReg    = w_ctrl.mem_to_reg;
    ALUSrc      = w_ctrl.alu_src;
    Add         = w_ctrl.add;
    Branch      = 1'b0;
    MemWrite    = 1'b0;
    RegWrite    = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    case (r_state)
      IDLE: begin
        instr_ready = 1'b1;
        busy        = 1'b0;
        ALUOp       = OPWIDTH'(ALUOP_PASS);
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        ALUSrc      = 1'b0;
        Add         = 1'b0;
        if (instr_valid && !stall) begin
          w_instr_nxt = instr;
          w_state_nxt = EXEC;
        end
      end
      EXEC: begin
        Branch = w_ctrl.branch;
        if (!stall) begin
          if (w_ctrl.is_mem) begin
            w_state_nxt = MEM;
            w_cnt_nxt   = CNT_W'(MEM_LAT - 1);
          end else begin
            w_state_nxt = WB;
          end
`ifdef CTRL_ILLEGAL_TRAP_EN
          if (w_ctrl.undef) begin
            w_state_nxt = TRAP;
          end
`endif
        end
      end
      MEM: begin
        if (r_cnt == '0) begin
          MemWrite = w_ctrl.mem_write & ~stall;
        end
        if (!stall) begin
          if (r_cnt == '0) begin
            w_state_nxt = WB;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
      end
      WB: begin
        RegWrite = w_ctrl.reg_write & ~stall;
        done     = ~stall;
        if (!stall) begin
          w_state_nxt = IDLE;
        end
      end
      TRAP: begin
        ALUOp    = OPWIDTH'(ALUOP_PASS);
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        ALUSrc   = 1'b0;
        Add      = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
        illegal  = 1'b1;
`else
        w_state_nxt = IDLE;
`endif
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control (OPBITS=4, MEM_LAT=3).
// Output vector order: {instr_ready,busy,done,RegDst,Branch,MemtoReg,MemWrite,ALUSrc,RegWrite,Add}
module tb_multicycle_control;

  localparam int unsigned MCODEBITS = 10;
  localparam int unsigned OPBITS    = 4;
  localparam int unsigned OPWIDTH   = 3;
  localparam int unsigned MEM_LAT   = 3;

  localparam logic [9:0] V_IDLE = 10'b1000000000;

  logic                 Clk = 1'b0;
  logic                 Reset;
  logic                 instr_valid;
  logic [MCODEBITS-1:0] instr;
  logic                 instr_ready;
  logic                 stall;
  logic                 RegDst, Branch, MemtoReg, MemWrite, ALUSrc, RegWrite, Add;
  logic [OPWIDTH-1:0]   ALUOp;
  logic                 busy, done, illegal;

  int n_checks = 0;
  int n_errors = 0;

  multicycle_control #(
    .MCODEBITS (MCODEBITS),
    .OPBITS    (OPBITS),
    .OPWIDTH   (OPWIDTH),
    .MEM_LAT   (MEM_LAT)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .stall       (stall),
    .RegDst      (RegDst),
    .Branch      (Branch),
    .MemtoReg    (MemtoReg),
    .MemWrite    (MemWrite),
    .ALUSrc      (ALUSrc),
    .RegWrite    (RegWrite),
    .Add         (Add),
    .ALUOp       (ALUOp),
    .busy        (busy),
    .done        (done),
    .illegal     (illegal)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] outs();
    return {instr_ready, busy, done, RegDst, Branch, MemtoReg, MemWrite, ALUSrc, RegWrite, Add};
  endfunction

  // Let combinational outputs settle after input changes, then compare everything
  task automatic expect_st(input string tag, input logic [9:0] v, input logic [2:0] alu,
                           input logic ill = 1'b0);
    #1;
    chk({tag, "_vec"}, 32'(outs()), 32'(v));
    chk({tag, "_aluop"}, 32'(ALUOp), 32'(alu));
    chk({tag, "_illegal"}, 32'(illegal), 32'(ill));
  endtask

  task automatic cyc();
    @(posedge Clk);
    #2;
  endtask

  initial begin
    Reset = 1'b1; stall = 1'b0; instr_valid = 1'b0; instr = '0;
    cyc();
    expect_st("reset", V_IDLE, 3'b111);
    Reset = 1'b0;
    cyc();
    expect_st("idle", V_IDLE, 3'b111);

    // add, with a second offer while busy that must be ignored
    instr_valid = 1'b1; instr = 10'b0001_010_011;
    expect_st("add_offer", V_IDLE, 3'b111);
    cyc();
    instr = 10'b0010_000_000;
    expect_st("add_exec", 10'b0101000101, 3'b001);
    cyc();
    instr_valid = 1'b0;
    expect_st("add_wb", 10'b0111000111, 3'b001);
    cyc();
    expect_st("add_idle", V_IDLE, 3'b111);

    // stall in IDLE blocks accept, then xor
    instr_valid = 1'b1; instr = 10'b0010_001_001; stall = 1'b1;
    cyc();
    expect_st("idle_stall", V_IDLE, 3'b111);
    stall = 1'b0;
    cyc();
    instr_valid = 1'b0;
    expect_st("xor_exec", 10'b0101000000, 3'b010);
    cyc();
    expect_st("xor_wb", 10'b0111000010, 3'b010);
    cyc();
    expect_st("xor_idle", V_IDLE, 3'b111);

    // load: done 2+MEM_LAT cycles after accept
    instr_valid = 1'b1; instr = 10'b0110_000_001;
    cyc();
    instr_valid = 1'b0;
    expect_st("ld_exec", 10'b0100010100, 3'b110);
    for (int i = 0; i < int'(MEM_LAT); i++) begin
      cyc();
      expect_st($sformatf("ld_mem%0d", i), 10'b0100010100, 3'b110);
    end
    cyc();
    expect_st("ld_wb", 10'b0110010110, 3'b110);
    cyc();
    expect_st("ld_idle", V_IDLE, 3'b111);

    // store with 2-cycle stall on the last MEM cycle
    instr_valid = 1'b1; instr = 10'b0111_000_000;
    cyc();
    instr_valid = 1'b0;
    expect_st("st_exec", 10'b0100000000, 3'b111);
    cyc();
    expect_st("st_mem2", 10'b0100000000, 3'b111);
    cyc();
    expect_st("st_mem1", 10'b0100000000, 3'b111);
    cyc();
    stall = 1'b1;
    expect_st("st_stall_a", 10'b0100000000, 3'b111);
    cyc();
    expect_st("st_stall_b", 10'b0100000000, 3'b111);
    cyc();
    stall = 1'b0;
    expect_st("st_memw", 10'b0100001000, 3'b111);
    cyc();
    expect_st("st_wb", 10'b0110000000, 3'b111);
    cyc();
    expect_st("st_idle", V_IDLE, 3'b111);

    // load stalled in WB: RegWrite and done suppressed
    instr_valid = 1'b1; instr = 10'b0110_000_010;
    cyc();
    instr_valid = 1'b0;
    for (int i = 0; i < int'(MEM_LAT) + 1; i++) cyc();
    stall = 1'b1;
    expect_st("ld_wb_stall", 10'b0100010100, 3'b110);
    cyc();
    stall = 1'b0;
    expect_st("ld_wb_go", 10'b0110010110, 3'b110);
    cyc();
    expect_st("ld2_idle", V_IDLE, 3'b111);

    // bne: Branch only in EXEC, no RegWrite
    instr_valid = 1'b1; instr = 10'b0011_000_000;
    cyc();
    instr_valid = 1'b0;
    expect_st("bne_exec", 10'b0100100000, 3'b011);
    cyc();
    expect_st("bne_wb", 10'b0110000000, 3'b011);
    cyc();
    expect_st("bne_idle", V_IDLE, 3'b111);

    // reset in the middle of a store's MEM phase
    instr_valid = 1'b1; instr = 10'b0111_000_000;
    cyc();
    instr_valid = 1'b0;
    cyc();
    expect_st("rst_mem", 10'b0100000000, 3'b111);
    Reset = 1'b1;
    expect_st("rst_async", V_IDLE, 3'b111);
    cyc();
    Reset = 1'b0;
    cyc();
    expect_st("rst_after", V_IDLE, 3'b111);
    cyc();
    expect_st("rst_after2", V_IDLE, 3'b111);

    // undefined opcode 4'b1000
    instr_valid = 1'b1; instr = 10'b1000_000_000;
    cyc();
    instr_valid = 1'b0;
    expect_st("undef_exec", 10'b0100000000, 3'b111);
    cyc();
`ifdef CTRL_ILLEGAL_TRAP_EN
    instr_valid = 1'b1; instr = 10'b0001_000_000;
    expect_st("trap_a", 10'b0100000000, 3'b111, 1'b1);
    cyc();
    expect_st("trap_b", 10'b0100000000, 3'b111, 1'b1);
    instr_valid = 1'b0;
    Reset = 1'b1;
    expect_st("trap_rst", V_IDLE, 3'b111);
    cyc();
    Reset = 1'b0;
    cyc();
    expect_st("trap_idle", V_IDLE, 3'b111);
`else
    expect_st("nop_wb", 10'b0110000000, 3'b111);
    cyc();
    expect_st("nop_idle", V_IDLE, 3'b111);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
